// File: rtl/seq_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | seq_serializer : FIFO-buffered parallel-to-serial front end; words are   |
// | shifted out back-to-back on p. Optional macro SER_PARITY_EN appends an   |
// | even-parity bit per word. Revision: 1.0                                  |
// +--------------------------------------------------------------------------+
module seq_serializer #(
  parameter int   WIDTH     = 8,
  parameter int   DEPTH     = 4,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           din,
  input  logic                       din_valid,
  output logic                       din_ready,
  input  logic                       flush,
  output logic                       p,
  output logic                       p_valid,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SHIFT  = 2'd1;
`ifdef SER_PARITY_EN
  localparam logic [1:0] c_PARITY = 2'd2;
`endif

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             p_q, p_d;
  logic             p_valid_q, p_valid_d;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_load;
  logic [WIDTH-1:0] w_head;

  assign w_full    = (level_q == LW'(DEPTH));
  assign w_empty   = (level_q == '0);
  assign din_ready = !w_full && !flush;
  assign w_push    = din_valid && din_ready;
  assign w_head    = mem_q[rd_ptr_q];

  assign p       = p_q;
  assign p_valid = p_valid_q;
  assign busy    = (state_q != c_IDLE);
  assign level   = level_q;

  // Shift register always holds the bits still to be emitted, aligned so the
  // next one sits at the output end.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    p_d     = IDLE_BIT;
    w_load  = 1'b0;
`ifdef SER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      c_IDLE: begin
        if (!w_empty) w_load = 1'b1;
      end
      c_SHIFT: begin
        if (cnt_q != '0) begin
          p_d    = (MSB_FIRST != 0) ? sreg_q[WIDTH-1] : sreg_q[0];
          sreg_d = (MSB_FIRST != 0) ? (sreg_q << 1) : (sreg_q >> 1);
          cnt_d  = cnt_q - 1'b1;
        end else begin
`ifdef SER_PARITY_EN
          state_d = c_PARITY;
          p_d     = par_q;
`else
          if (!w_empty) w_load = 1'b1;
          else          state_d = c_IDLE;
`endif
        end
      end
`ifdef SER_PARITY_EN
      c_PARITY: begin
        if (!w_empty) w_load = 1'b1;
        else          state_d = c_IDLE;
      end
`endif
      default: state_d = c_IDLE;
    endcase

    if (w_load) begin
      p_d     = (MSB_FIRST != 0) ? w_head[WIDTH-1] : w_head[0];
      sreg_d  = (MSB_FIRST != 0) ? (w_head << 1) : (w_head >> 1);
      cnt_d   = CW'(WIDTH - 1);
      state_d = c_SHIFT;
`ifdef SER_PARITY_EN
      par_d   = ^w_head;
`endif
    end

    if (flush) begin
      state_d = c_IDLE;
      p_d     = IDLE_BIT;
    end
    p_valid_d = (state_d != c_IDLE);
  end

  assign w_pop = w_load && !flush;

  always_comb begin
    wr_ptr_d = w_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = w_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    case ({w_push, w_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      state_q   <= c_IDLE;
      cnt_q     <= '0;
      sreg_q    <= '0;
      p_q       <= IDLE_BIT;
      p_valid_q <= 1'b0;
`ifdef SER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sreg_q    <= sreg_d;
      p_q       <= p_d;
      p_valid_q <= p_valid_d;
`ifdef SER_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_seq_serializer : directed self-checking bench for seq_serializer      |
// | (WIDTH=8, DEPTH=4, MSB first, IDLE_BIT=0). Revision: 1.0                 |
// +--------------------------------------------------------------------------+
module tb_seq_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       flush = 1'b0;
  logic       p;
  logic       p_valid;
  logic       busy;
  logic [2:0] level;

  int n_tests = 0;
  int n_fail  = 0;
  int nv, nones, acc, guard;

  seq_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .flush     (flush),
    .p         (p),
    .p_valid   (p_valid),
    .busy      (busy),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts accepted words before the edge and emitted bits after it.
  task automatic tick();
    if (din_valid && din_ready) acc++;
    @(posedge clk);
    #1;
    if (p_valid) begin
      nv++;
      if (p) nones++;
    end
  endtask

  task automatic expect_frame(input string tag, input logic [63:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_pv"}, {31'd0, p_valid}, 32'd1);
      chk({tag, "_p"},  {31'd0, p}, {31'd0, bits[n-1-i]});
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      step();
    end
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_idle_pv"}, {31'd0, p_valid}, 32'd0);
    chk({tag, "_idle_p"},  {31'd0, p}, 32'd0);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_idle_lvl"}, {29'd0, level}, 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    expect_idle("rst");
    step();
    rst = 1'b1;
    #1;
    chk("rst_ready", {31'd0, din_ready}, 32'd1);

`ifndef SER_PARITY_EN
    // Single word 8'hFF
    din = 8'hFF; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    chk("ff_lvl_acc", {29'd0, level}, 32'd1);
    chk("ff_pv_lat",  {31'd0, p_valid}, 32'd0);
    step();
    chk("ff_lvl_pop", {29'd0, level}, 32'd0);
    expect_frame("ff", 64'hFF, 8);
    expect_idle("ff");

    // Back-to-back A5, 3C
    din = 8'hA5; din_valid = 1'b1;
    step();
    din = 8'h3C;
    step();
    din_valid = 1'b0;
    expect_frame("a53c", 64'hA53C, 16);
    expect_idle("a53c");

    // Sustained push of 8'hFF every clock
    nv = 0; nones = 0; acc = 0;
    din = 8'hFF; din_valid = 1'b1;
    tick();
    chk("sus_lvl1", {29'd0, level}, 32'd1);
    tick();
    chk("sus_lvl1b", {29'd0, level}, 32'd1);
    tick(); tick(); tick();
    chk("sus_lvl4", {29'd0, level}, 32'd4);
    chk("sus_rdy_lo0", {31'd0, din_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sus_rdy_lo", {31'd0, din_ready}, 32'd0);
    end
    tick();
    chk("sus_rdy_hi", {31'd0, din_ready}, 32'd1);
    din_valid = 1'b0;
    guard = 0;
    while (p_valid && guard < 100) begin
      tick();
      guard++;
    end
    chk("sus_timeout", {31'd0, p_valid}, 32'd0);
    chk("sus_acc", acc, 32'd5);
    chk("sus_nv", nv, 32'd40);
    chk("sus_ones", nones, 32'd40);
    expect_idle("sus");

    // Flush during bit 3 with two words queued
    din = 8'h11; din_valid = 1'b1;
    step();
    din = 8'h22;
    step();
    din = 8'h33;
    step();
    din_valid = 1'b0;
    step(); step();
    chk("fl_lvl_pre", {29'd0, level}, 32'd2);
    chk("fl_bit3", {31'd0, p}, 32'd1);
    flush = 1'b1;
    #1;
    chk("fl_rdy_lo", {31'd0, din_ready}, 32'd0);
    step();
    flush = 1'b0;
    #1;
    expect_idle("fl");
    chk("fl_rdy", {31'd0, din_ready}, 32'd1);
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (p_valid) nv++;
    end
    chk("fl_quiet", nv, 32'd0);

    // Asynchronous reset mid-word
    din = 8'hFF; din_valid = 1'b1;
    step();
    step();
    din_valid = 1'b0;
    step(); step();
    chk("ar_pre_pv", {31'd0, p_valid}, 32'd1);
    chk("ar_pre_lvl", {29'd0, level}, 32'd1);
    #3;
    rst = 1'b0;
    #1;
    expect_idle("ar");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("ar_rdy", {31'd0, din_ready}, 32'd1);
    din = 8'h81; din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    step();
    expect_frame("ar81", 64'h81, 8);
    expect_idle("ar81");
`else
    // Parity frames: 07 -> parity 1, 03 -> parity 0
    din = 8'h07; din_valid = 1'b1;
    step();
    din = 8'h03;
    step();
    din_valid = 1'b0;
    expect_frame("par", {46'd0, 8'h07, 1'b1, 8'h03, 1'b0}, 18);
    expect_idle("par");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
